// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture path.
// Clock and duty-width defaults are common with the breathing-LED generator.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } cap_state_t;

    localparam int unsigned CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned DUTY_W      = 9;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider: quot = floor(num * 2^WIDTH / den), one bit per cycle.
// Requires num < den so the quotient fits WIDTH bits.
module pwm_duty_div
    import pwm_capture_pkg::*;
#(
    parameter int unsigned WIDTH = DUTY_W,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num,
    input  logic [CNT_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_den;
    logic [WIDTH-1:0] r_quot;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [CNT_W-1:0] w_rem_src;
    logic [CNT_W-1:0] w_den_src;
    logic [CNT_W:0]   w_shift;
    logic [CNT_W-1:0] w_diff;
    logic             w_ge;
    logic [CNT_W-1:0] w_rem_nxt;

    // The first quotient bit is resolved in the start cycle itself.
    assign w_rem_src = start ? num : r_rem;
    assign w_den_src = start ? den : r_den;
    assign w_shift   = {w_rem_src, 1'b0};
    assign w_ge      = (w_shift >= {1'b0, w_den_src});
    assign w_diff    = w_shift[CNT_W-1:0] - w_den_src;
    assign w_rem_nxt = w_ge ? w_diff : w_shift[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_den  <= den;
                r_rem  <= w_rem_nxt;
                r_quot <= WIDTH'(w_ge);
                r_cnt  <= CW'(WIDTH - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= w_rem_nxt;
                r_quot <= (r_quot << 1) | WIDTH'(w_ge);
                r_cnt  <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign quot = r_quot;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time, period and normalised duty of an external PWM input,
// with stuck-high / stuck-low detection when edges stop arriving.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned FREQUENCE = CLK_FREQ_HZ,
    parameter int unsigned WIDTH     = DUTY_W,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TIMEOUT   = FREQUENCE / 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] duty,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             overrun,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    logic r_s0, r_s1, r_s2;
    logic w_rise, w_fall, w_edge;

    cap_state_t r_state, w_state_nxt;

    logic [CNT_W-1:0] r_hcnt, r_lcnt, r_ecnt;
    logic [CNT_W-1:0] r_cap_high, r_cap_period;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_period;
    logic             r_start;

    logic             w_timeout, w_capture, w_accept, w_ovr;
    logic             w_div_rst, w_div_busy, w_busy, w_done;
    logic [WIDTH-1:0] w_quot;

    logic [WIDTH-1:0] r_duty;
    logic [CNT_W-1:0] r_high_cnt, r_period_cnt;
    logic             r_valid, r_overrun, r_stuck_hi, r_stuck_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s0 <= pwm_in;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    assign w_rise = r_s1 & ~r_s2;
    assign w_fall = ~r_s1 & r_s2;
    assign w_edge = w_rise | w_fall;

    assign w_timeout = (r_ecnt == CNT_W'(TIMEOUT - 1)) && !w_edge;
    // Busy spans start request through done, so a capture never collides with output update.
    assign w_div_busy = r_start | w_busy | w_done;
    assign w_capture  = (r_state == ST_LOW) && w_rise;
    assign w_accept   = w_capture && !w_div_busy;
    assign w_ovr      = w_capture && w_div_busy;
    assign w_div_rst  = rst | w_timeout;

    assign w_sum    = {1'b0, r_hcnt} + {1'b0, r_lcnt};
    assign w_period = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_rise) w_state_nxt = ST_HIGH;
            ST_HIGH: if (w_fall) w_state_nxt = ST_LOW;
            ST_LOW:  if (w_rise) w_state_nxt = ST_HIGH;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || w_timeout) begin
            r_hcnt <= '0;
            r_lcnt <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) r_hcnt <= CNT_W'(1);
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        r_lcnt <= CNT_W'(1);
                    end else if (r_hcnt != '1) begin
                        r_hcnt <= r_hcnt + CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        r_hcnt <= CNT_W'(1);
                    end else if (r_lcnt != '1) begin
                        r_lcnt <= r_lcnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_hcnt <= '0;
                    r_lcnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_high   <= '0;
            r_cap_period <= '0;
            r_start      <= 1'b0;
        end else begin
            r_start <= w_accept;
            if (w_accept) begin
                r_cap_high   <= r_hcnt;
                r_cap_period <= w_period;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_edge) begin
            r_ecnt <= '0;
        end else if (r_ecnt != '1) begin
            r_ecnt <= r_ecnt + CNT_W'(1);
        end
    end

    pwm_duty_div #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst   (w_div_rst),
        .start (r_start),
        .num   (r_cap_high),
        .den   (r_cap_period),
        .busy  (w_busy),
        .done  (w_done),
        .quot  (w_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty       <= '0;
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_stuck_hi   <= 1'b0;
            r_stuck_lo   <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_overrun <= w_ovr;
            if (w_edge) begin
                r_stuck_hi <= 1'b0;
                r_stuck_lo <= 1'b0;
            end
            if (w_timeout) begin
                r_stuck_hi   <= r_s2;
                r_stuck_lo   <= ~r_s2;
                r_duty       <= r_s2 ? '1 : '0;
                r_high_cnt   <= '0;
                r_period_cnt <= '0;
                r_valid      <= 1'b1;
            end else if (w_done) begin
                r_duty       <= w_quot;
                r_high_cnt   <= r_cap_high;
                r_period_cnt <= r_cap_period;
                r_valid      <= 1'b1;
            end
        end
    end

    assign duty       = r_duty;
    assign high_cnt   = r_high_cnt;
    assign period_cnt = r_period_cnt;
    assign valid      = r_valid;
    assign overrun    = r_overrun;
    assign stuck_hi   = r_stuck_hi;
    assign stuck_lo   = r_stuck_lo;

endmodule
